spi_config_sequencer: RTL and testbench

Parametrised successor to the fixed CDCE configuration chain. It merges command control and serial output into one ROM-driven SPI configuration engine. It supports configurable word width, up to 4 chip selects, a programmable SCLK divider, timed delays and read-back verification. It sits between a registered command ROM and one or more SPI-configured devices (clock synthesisers, DACs). It reports done and error to the system reset and bring-up logic.

---
 rtl/spi_config_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_spi_config_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_config_sequencer.sv
// ROM-driven SPI configuration engine: walks a command ROM issuing mode-0 writes,
// read-back verifies and timed delays, then reports done/error to bring-up logic.
module spi_config_sequencer #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NUM_CS     = 1,
    parameter int unsigned SCLK_DIV   = 2,
    parameter int unsigned CS_GAP     = 4,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic [3:0]            rom_command,
    input  logic [WORD_WIDTH-1:0] rom_data,
    output logic                  sclk,
    output logic [NUM_CS-1:0]     cs_n,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  pdn,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] error_address
);

    localparam int unsigned PhaseLast = 2 * WORD_WIDTH + 1;
    localparam int unsigned PhaseW    = $clog2(PhaseLast + 1);
    localparam int unsigned GapRaw    = CS_GAP * SCLK_DIV;
    // FETCH and DECODE also keep cs_n high, so they are counted as part of the gap.
    localparam int unsigned GapCycles = (GapRaw > 2) ? GapRaw - 2 : 1;
    localparam int unsigned DelayW    = (WORD_WIDTH < 16) ? WORD_WIDTH : 16;

    localparam logic [PhaseW-1:0] PhaseLastL   = PhaseW'(PhaseLast);
    localparam logic [PhaseW-1:0] PhaseRiseEnd = PhaseW'(2 * WORD_WIDTH);
    localparam logic [31:0]       DivEnd       = 32'(SCLK_DIV - 1);
    localparam logic [31:0]       GapEnd       = 32'(GapCycles - 1);
    localparam logic [2:0]        NumCsL       = 3'(NUM_CS);

    localparam logic [1:0] OpEnd    = 2'd0;
    localparam logic [1:0] OpWrite  = 2'd1;
    localparam logic [1:0] OpVerify = 2'd2;
    localparam logic [1:0] OpDelay  = 2'd3;

    typedef enum logic [3:0] {
        StIdle, StFetch, StDecode, StShift, StGap, StDelay, StFetchExp, StCompare, StFinish
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WORD_WIDTH-1:0]   shreg_q, shreg_d;
    logic [WORD_WIDTH-1:0]   cap_q, cap_d;
    logic [PhaseW-1:0]       phase_q, phase_d;
    logic [31:0]             div_q, div_d;
    logic [31:0]             cnt_q, cnt_d;
    logic [1:0]              cs_idx_q, cs_idx_d;
    logic                    is_verify_q, is_verify_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;
    logic                    auto_q, auto_d;

    logic   launch;
    logic   advance;
    state_e adv_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            shreg_q     <= '0;
            cap_q       <= '0;
            phase_q     <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            cs_idx_q    <= '0;
            is_verify_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_addr_q  <= '0;
            auto_q      <= AUTO_START;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            shreg_q     <= shreg_d;
            cap_q       <= cap_d;
            phase_q     <= phase_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            cs_idx_q    <= cs_idx_d;
            is_verify_q <= is_verify_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_addr_q  <= err_addr_d;
            auto_q      <= auto_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        shreg_d     = shreg_q;
        cap_d       = cap_q;
        phase_d     = phase_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        cs_idx_d    = cs_idx_q;
        is_verify_d = is_verify_q;
        done_d      = done_q;
        error_d     = error_q;
        err_addr_d  = err_addr_q;
        auto_d      = auto_q;
        advance     = 1'b0;
        adv_state   = StFetch;

        launch = ((state_q == StIdle) && (start || auto_q)) || ((state_q == StFinish) && start);

        unique case (state_q)
            StIdle, StFinish: begin
                if (launch) begin
                    auto_d     = 1'b0;
                    addr_d     = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_addr_d = '0;
                    state_d    = StFetch;
                end
            end
            StFetch:    state_d = StDecode;
            StFetchExp: state_d = StCompare;
            StDecode: begin
                cs_idx_d    = rom_command[3:2];
                is_verify_d = (rom_command[1:0] == OpVerify);
                if ((rom_command[1:0] != OpEnd) && ({1'b0, rom_command[3:2]} >= NumCsL)) begin
                    state_d    = StFinish;
                    done_d     = 1'b1;
                    error_d    = 1'b1;
                    err_addr_d = addr_q;
                end else begin
                    unique case (rom_command[1:0])
                        OpEnd: begin
                            state_d = StFinish;
                            done_d  = 1'b1;
                        end
                        OpWrite, OpVerify: begin
                            shreg_d = rom_data;
                            phase_d = '0;
                            div_d   = '0;
                            state_d = StShift;
                        end
                        OpDelay: begin
                            if (rom_data[DelayW-1:0] == '0) begin
                                advance = 1'b1;
                            end else begin
                                cnt_d   = 32'(rom_data[DelayW-1:0]);
                                state_d = StDelay;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StShift: begin
                if (div_q == DivEnd) begin
                    div_d   = '0;
                    phase_d = phase_q + 1'b1;
                    // Even -> odd phase is the SCLK rising edge, odd -> even the falling edge.
                    if (!phase_q[0] && (phase_q < PhaseRiseEnd)) begin
                        cap_d = {cap_q[WORD_WIDTH-2:0], miso};
                    end
                    if (phase_q[0] && (phase_q < PhaseLastL)) begin
                        shreg_d = {shreg_q[WORD_WIDTH-2:0], 1'b0};
                    end
                    if (phase_q == PhaseLastL) begin
                        cnt_d   = '0;
                        state_d = StGap;
                    end
                end else begin
                    div_d = div_q + 32'd1;
                end
            end
            StGap: begin
                if (cnt_q == GapEnd) begin
                    advance   = 1'b1;
                    adv_state = is_verify_q ? StFetchExp : StFetch;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StDelay: begin
                if (cnt_q == 32'd1) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            StCompare: begin
                if (cap_q == rom_data) begin
                    advance = 1'b1;
                end else begin
                    state_d    = StFinish;
                    done_d     = 1'b1;
                    error_d    = 1'b1;
                    err_addr_d = addr_q;
                end
            end
            default: state_d = StIdle;
        endcase

        // Running off the end of the ROM means the END marker is missing.
        if (advance) begin
            if (addr_q == '1) begin
                state_d    = StFinish;
                done_d     = 1'b1;
                error_d    = 1'b1;
                err_addr_d = '1;
            end else begin
                addr_d  = addr_q + 1'b1;
                state_d = adv_state;
            end
        end
    end

    always_comb begin
        cs_n = '1;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if ((state_q == StShift) && (cs_idx_q == 2'(i))) begin
                cs_n[i] = 1'b0;
            end
        end
        sclk          = (state_q == StShift) && phase_q[0] && (phase_q != PhaseLastL);
        mosi          = (state_q == StShift) && shreg_q[WORD_WIDTH-1];
        pdn           = 1'b1;
        busy          = (state_q != StIdle) && (state_q != StFinish);
        done          = done_q;
        error         = error_q;
        error_address = err_addr_q;
        rom_address   = addr_q;
    end

endmodule

// File: tb/tb_spi_config_sequencer.sv
// Directed bench for spi_config_sequencer: registered ROM model, mode-0 slave and
// a bus monitor measuring frame length, gaps, SCLK edges and shifted data.
module tb_spi_config_sequencer;

    localparam int unsigned WW  = 32;
    localparam int unsigned AW  = 4;
    localparam int unsigned NCS = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] rom_address;
    logic [3:0]    rom_command = '0;
    logic [WW-1:0] rom_data = '0;
    logic          sclk;
    logic [NCS-1:0] cs_n;
    logic          mosi;
    logic          miso;
    logic          pdn;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] error_address;

    int tests_run = 0;
    int tests_failed = 0;

    spi_config_sequencer #(
        .WORD_WIDTH(WW),
        .ADDR_WIDTH(AW),
        .NUM_CS    (NCS),
        .SCLK_DIV  (2),
        .CS_GAP    (4),
        .AUTO_START(1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rom_address  (rom_address),
        .rom_command  (rom_command),
        .rom_data     (rom_data),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .mosi         (mosi),
        .miso         (miso),
        .pdn          (pdn),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .error_address(error_address)
    );

    always #5 clk = ~clk;

    logic [3:0]  cmd_mem [16];
    logic [31:0] dat_mem [16];

    always @(posedge clk) begin
        rom_command <= cmd_mem[rom_address];
        rom_data    <= dat_mem[rom_address];
    end

    // Monitor and slave, sampled on the falling clk edge.
    int          cycle = 0;
    int          frames = 0;
    int          rises_total = 0;
    int          rises_in_frame = 0;
    int          cur_low = 0;
    int          last_low_len = 0;
    int          cur_high = 0;
    int          last_gap_len = 0;
    int          fall_cycle = 0;
    int          violations = 0;
    logic [31:0] mosi_word = '0;
    logic [1:0]  last_cs = 2'b11;
    logic [1:0]  cs_prev = 2'b11;
    logic        sclk_prev = 1'b0;
    logic [31:0] slave_sr = '0;
    logic [31:0] slave_resp = '0;

    assign miso = slave_sr[31];

    always @(negedge clk) begin
        cycle++;
        if (cs_n != 2'b11) begin
            if (cs_prev == 2'b11) begin
                frames++;
                cur_low        = 0;
                rises_in_frame = 0;
                last_cs        = cs_n;
                fall_cycle     = cycle;
                last_gap_len   = cur_high;
                slave_sr       = slave_resp;
            end
            cur_low++;
        end else begin
            if (cs_prev != 2'b11) begin
                last_low_len = cur_low;
                cur_high     = 0;
            end
            cur_high++;
        end
        if (sclk && !sclk_prev) begin
            rises_total++;
            rises_in_frame++;
            mosi_word = {mosi_word[30:0], mosi};
        end
        if (!sclk && sclk_prev) begin
            slave_sr = {slave_sr[30:0], 1'b0};
        end
        if ((cs_n == 2'b00) || (sclk && (cs_n == 2'b11))) begin
            violations++;
        end
        cs_prev   = cs_n;
        sclk_prev = sclk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] cmd(input int cs, input logic [1:0] op);
        return {2'(cs), op};
    endfunction

    task automatic hold_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            cmd_mem[i] = 4'h0;
            dat_mem[i] = 32'h0;
        end
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, done, 1);
    endtask

    int f0;
    int r0;
    int rel_cycle;
    int n;

    initial begin
        // Reset values while reset is held.
        hold_reset();
        check("rst_addr", rom_address, 0);
        check("rst_sclk", sclk, 0);
        check("rst_cs_n", cs_n, 2'b11);
        check("rst_mosi", mosi, 0);
        check("rst_pdn", pdn, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_err_addr", error_address, 0);

        // Single auto-started WRITE.
        hold_reset();
        cmd_mem[0] = cmd(0, 2'd1);
        dat_mem[0] = 32'h8000_0013;
        f0 = frames;
        r0 = rises_total;
        @(negedge clk);
        reset = 1'b0;
        wait_done(400, "w1");
        check("w1_frames", frames - f0, 1);
        check("w1_low_len", last_low_len, 132);
        check("w1_rises", rises_total - r0, 32);
        check("w1_mosi", mosi_word, 32'h8000_0013);
        check("w1_cs", last_cs, 2'b10);
        check("w1_error", error, 0);
        check("w1_busy", busy, 0);
        check("w1_cs_idle", cs_n, 2'b11);

        // Two WRITEs on different chip selects.
        hold_reset();
        cmd_mem[0] = cmd(1, 2'd1);
        dat_mem[0] = 32'h1234_5678;
        cmd_mem[1] = cmd(0, 2'd1);
        dat_mem[1] = 32'hCAFE_F00D;
        f0 = frames;
        @(negedge clk);
        reset = 1'b0;
        wait_done(600, "w2");
        check("w2_frames", frames - f0, 2);
        check("w2_gap", last_gap_len, 8);
        check("w2_addr", rom_address, 2);
        check("w2_mosi", mosi_word, 32'hCAFE_F00D);
        check("w2_cs", last_cs, 2'b10);
        check("w2_error", error, 0);

        // VERIFY with matching read-back; expected word's command field is junk.
        hold_reset();
        cmd_mem[0] = cmd(0, 2'd2);
        dat_mem[0] = 32'h0000_000E;
        cmd_mem[1] = 4'hF;
        dat_mem[1] = 32'hA5A5_0001;
        slave_resp = 32'hA5A5_0001;
        f0 = frames;
        @(negedge clk);
        reset = 1'b0;
        wait_done(400, "v_ok");
        check("v_ok_error", error, 0);
        check("v_ok_frames", frames - f0, 1);
        check("v_ok_mosi", mosi_word, 32'h0000_000E);
        check("v_ok_addr", rom_address, 2);

        // VERIFY mismatch stops before the following WRITE.
        hold_reset();
        cmd_mem[0] = cmd(0, 2'd2);
        dat_mem[0] = 32'h0000_000E;
        dat_mem[1] = 32'hA5A5_0001;
        cmd_mem[2] = cmd(0, 2'd1);
        dat_mem[2] = 32'h0000_00FF;
        slave_resp = 32'hA5A5_0000;
        f0 = frames;
        @(negedge clk);
        reset = 1'b0;
        wait_done(400, "v_bad");
        repeat (300) @(negedge clk);
        check("v_bad_error", error, 1);
        check("v_bad_err_addr", error_address, 1);
        check("v_bad_frames", frames - f0, 1);
        check("v_bad_done_held", done, 1);

        // DELAY 1000 before a WRITE.
        hold_reset();
        cmd_mem[0] = cmd(0, 2'd3);
        dat_mem[0] = 32'd1000;
        cmd_mem[1] = cmd(0, 2'd1);
        dat_mem[1] = 32'h0000_0005;
        f0 = frames;
        @(negedge clk);
        reset = 1'b0;
        rel_cycle = cycle;
        wait_done(1500, "dly");
        check("dly_min", (fall_cycle - rel_cycle) >= 1000, 1);
        check("dly_max", (fall_cycle - rel_cycle) <= 1010, 1);
        check("dly_frames", frames - f0, 1);
        check("dly_mosi", mosi_word, 32'h0000_0005);
        check("dly_error", error, 0);

        // Chip-select index beyond NUM_CS.
        hold_reset();
        cmd_mem[0] = cmd(2, 2'd1);
        dat_mem[0] = 32'h1111_1111;
        f0 = frames;
        @(negedge clk);
        reset = 1'b0;
        wait_done(50, "bad_cs");
        check("bad_cs_error", error, 1);
        check("bad_cs_err_addr", error_address, 0);
        check("bad_cs_frames", frames - f0, 0);

        // Reset in the middle of a frame, then auto-restart.
        hold_reset();
        cmd_mem[0] = cmd(0, 2'd1);
        dat_mem[0] = 32'hDEAD_BEEF;
        f0 = frames;
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (!((frames > f0) && (rises_in_frame >= 10)) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("mid_reached", n < 1000, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_cs_n", cs_n, 2'b11);
        check("mid_sclk", sclk, 0);
        check("mid_busy", busy, 0);
        check("mid_addr", rom_address, 0);
        f0 = frames;
        reset = 1'b0;
        wait_done(400, "mid");
        check("mid_frames", frames - f0, 1);
        check("mid_mosi", mosi_word, 32'hDEAD_BEEF);
        check("mid_low_len", last_low_len, 132);
        check("mid_error", error, 0);

        // No END anywhere: 16 frames, then wrap error.
        hold_reset();
        for (int i = 0; i < 16; i++) begin
            cmd_mem[i] = cmd(0, 2'd1);
            dat_mem[i] = 32'h1000_0000 + 32'(i);
        end
        f0 = frames;
        @(negedge clk);
        reset = 1'b0;
        wait_done(3000, "wrap");
        check("wrap_frames", frames - f0, 16);
        check("wrap_error", error, 1);
        check("wrap_err_addr", error_address, 4'hF);
        check("wrap_mosi", mosi_word, 32'h1000_000F);
        check("wrap_busy", busy, 0);

        // Start pulse from done restarts at address 0 with error cleared.
        cmd_mem[1] = 4'h0;
        f0 = frames;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_busy", busy, 1);
        check("restart_error", error, 0);
        check("restart_done", done, 0);
        check("restart_addr", rom_address, 0);
        wait_done(400, "restart");
        check("restart_end_error", error, 0);
        check("restart_end_addr", rom_address, 1);
        check("restart_frames", frames - f0, 1);
        check("restart_mosi", mosi_word, 32'h1000_0000);

        check("bus_violations", violations, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
